// File: rtl/univ_shift_reg_pkg.sv
// Package: shift_reg_pkg
// Purpose: operation codes shared by the universal shift register and its users.
//   The mode field is 3 bits wide. Codes 6 and 7 are reserved: the register
//   treats them exactly like HOLD (q and the shift count are left untouched).
package shift_reg_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'd0;  // q unchanged
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'd1;  // shift left, sin_l enters bit 0
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'd2;  // shift right, sin_r enters MSB
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'd3;  // parallel load from din
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'd4;  // rotate left
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'd5;  // rotate right
  // 3'd6 and 3'd7 are reserved and decode as HOLD.

  // True for the four modes that move bits and therefore advance the shift count.
  function automatic logic is_shift_mode(input logic [MODE_W-1:0] m);
    return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) || (m == MODE_ROR);
  endfunction

endpackage

// File: rtl/dff_async_bit.sv
// Module: dff_async_bit
// Purpose: single-bit D flip-flop, rising-edge clocked, asynchronous active-low
//   reset to a parameterised value. One instance per register bit.
// Ports:
//   clk    in  rising-edge clock
//   reset  in  asynchronous, active-low reset
//   d      in  next-state data
//   q      out registered data
module dff_async_bit #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= RESET_VAL;
    else        q <= d;
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Module: univ_shift_reg
// Purpose: parameterised multi-mode register: hold, shift left/right, parallel
//   load, rotate left/right. Provides true/complement outputs, serial outputs at
//   both ends and a one-cycle pulse after every WIDTH shifts since load/reset.
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-low reset
//   en          in   clock enable; 0 holds q and the shift count
//   mode        in   [2:0] operation select (codes in shift_reg_pkg)
//   din         in   [WIDTH-1:0] parallel load data
//   sin_l       in   serial in, enters q[0] on shift left
//   sin_r       in   serial in, enters q[WIDTH-1] on shift right
//   q           out  [WIDTH-1:0] register contents
//   qb          out  [WIDTH-1:0] ~q
//   sout_l      out  q[WIDTH-1]
//   sout_r      out  q[0]
//   shift_done  out  one-cycle pulse after the WIDTH-th shift/rotate
// There is no handshake on this block: every enabled rising edge is one
// operation, the result is visible one cycle later.
module univ_shift_reg
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             sout_l,
  output logic             sout_r,
  output logic             shift_done
);

  localparam int               CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] q_next;
  logic [CW-1:0]    count;
  logic             shifting;

  // Next-state mux. When disabled or on HOLD/reserved codes the flops reload q.
  always_comb begin
    q_next = q;
    if (en) begin
      case (mode)
        MODE_SHL:  q_next = {q[WIDTH-2:0], sin_l};
        MODE_SHR:  q_next = {sin_r, q[WIDTH-1:1]};
        MODE_LOAD: q_next = din;
        MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
        MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
        default:   q_next = q;
      endcase
    end
  end

  assign shifting = en && is_shift_mode(mode);

  // One flop per bit so each bit carries its own reset value.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_async_bit #(
      .RESET_VAL(RESET_VALUE[i])
    ) u_bit (
      .clk  (clk),
      .reset(reset),
      .d    (q_next[i]),
      .q    (q[i])
    );
  end

  // Shift counter: LOAD restarts the sequence; the WIDTH-th shift wraps the
  // count and raises shift_done for exactly the following cycle. Directions
  // are not distinguished.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count      <= '0;
      shift_done <= 1'b0;
    end else if (!en) begin
      shift_done <= 1'b0;
    end else if (mode == MODE_LOAD) begin
      count      <= '0;
      shift_done <= 1'b0;
    end else if (shifting) begin
      if (count == LAST) begin
        count      <= '0;
        shift_done <= 1'b1;
      end else begin
        count      <= count + CW'(1);
        shift_done <= 1'b0;
      end
    end else begin
      shift_done <= 1'b0;
    end
  end

  assign qb     = ~q;
  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: an 8-bit instance (reset value 0) and a 16-bit
// instance (reset value 16'h005A) share clock, reset and control inputs.
// A behavioural model tracks both and every cycle is compared.
module tb_univ_shift_reg;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        en;
  logic [2:0]  mode;
  logic [15:0] din16;
  logic [7:0]  din8;
  logic        sin_l, sin_r;

  logic [7:0]  q8, qb8;
  logic        sout_l8, sout_r8, done8;
  logic [15:0] q16, qb16;
  logic        sout_l16, sout_r16, done16;

  assign din8 = din16[7:0];

  univ_shift_reg #(.WIDTH(8), .RESET_VALUE(8'h00)) dut8 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .din(din8),
    .sin_l(sin_l), .sin_r(sin_r), .q(q8), .qb(qb8),
    .sout_l(sout_l8), .sout_r(sout_r8), .shift_done(done8)
  );

  univ_shift_reg #(.WIDTH(16), .RESET_VALUE(16'h005A)) dut16 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .din(din16),
    .sin_l(sin_l), .sin_r(sin_r), .q(q16), .qb(qb16),
    .sout_l(sout_l16), .sout_r(sout_r16), .shift_done(done16)
  );

  // ---------------- reference model ----------------
  logic [15:0] mq8, mq16;
  int          mc8, mc16;     // shifts since last load/reset
  logic        md8, md16;     // expected shift_done

  int n_assert = 0;
  int n_fail   = 0;

  function automatic logic [15:0] model_next(input int w, input logic [15:0] q,
                                             input int m, input logic [15:0] d,
                                             input logic sl, input logic sr);
    logic [15:0] mask;
    mask = (16'h1 << w) - 16'h1;
    if (w == 16) mask = 16'hFFFF;
    case (m)
      1:       return ((q << 1) | {15'd0, sl}) & mask;
      2:       return (q >> 1) | ({15'd0, sr} << (w - 1));
      3:       return d & mask;
      4:       return ((q << 1) | (q >> (w - 1))) & mask;
      5:       return (q >> 1) | ({15'd0, q[0]} << (w - 1));
      default: return q;
    endcase
  endfunction

  task automatic model_edge(input int w, inout logic [15:0] q, inout int c,
                            inout logic d);
    d = 1'b0;
    if (en) begin
      q = model_next(w, q, int'(mode), din16, sin_l, sin_r);
      if (mode == 3'd3) c = 0;
      else if (mode inside {3'd1, 3'd2, 3'd4, 3'd5}) begin
        c = c + 1;
        if (c == w) begin
          c = 0;
          d = 1'b1;
        end
      end
    end
  endtask

  task automatic model_reset();
    mq8 = 16'h0000; mq16 = 16'h005A;
    mc8 = 0; mc16 = 0; md8 = 1'b0; md16 = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " q8"},      {8'h00, q8},   mq8);
    chk({tag, " qb8"},     {8'h00, qb8},  {8'h00, ~mq8[7:0]});
    chk({tag, " sout_l8"}, {15'd0, sout_l8}, {15'd0, mq8[7]});
    chk({tag, " sout_r8"}, {15'd0, sout_r8}, {15'd0, mq8[0]});
    chk({tag, " done8"},   {15'd0, done8},   {15'd0, md8});
    chk({tag, " q16"},     q16,  mq16);
    chk({tag, " qb16"},    qb16, ~mq16);
    chk({tag, " sout16"},  {14'd0, sout_l16, sout_r16}, {14'd0, mq16[15], mq16[0]});
    chk({tag, " done16"},  {15'd0, done16},  {15'd0, md16});
  endtask

  // ---------------- drivers (called at negedge) ----------------
  task automatic step(input string tag, input logic e, input logic [2:0] m,
                      input logic [15:0] d, input logic sl, input logic sr);
    en = e; mode = m; din16 = d; sin_l = sl; sin_r = sr;
    @(posedge clk);
    model_edge(8, mq8, mc8, md8);
    model_edge(16, mq16, mc16, md16);
    @(negedge clk);
    check_all(tag);
  endtask

  // Asserts reset between edges, checks the immediate effect, releases at a later negedge.
  task automatic pulse_reset(input string tag);
    #2 reset = 1'b0;
    model_reset();
    #1 check_all({tag, " async"});
    @(posedge clk);
    @(negedge clk);
    check_all({tag, " held"});
    reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; en = 1'b0; mode = 3'd0; din16 = 16'h0; sin_l = 1'b0; sin_r = 1'b0;
    model_reset();
    @(negedge clk);
    check_all("reset");
    chk("reset q16 value", q16, 16'h005A);
    @(negedge clk);
    reset = 1'b1;

    // Async reset while q holds A5
    step("load_a5", 1'b1, 3'd3, 16'h00A5, 1'b0, 1'b0);
    chk("pre-reset q8", {8'h00, q8}, 16'h00A5);
    pulse_reset("mid_reset");
    chk("reset qb8", {8'h00, qb8}, 16'h00FF);

    // LOAD A5, SHL sin_l=1, SHR sin_r=0
    step("load_a5b", 1'b1, 3'd3, 16'h00A5, 1'b0, 1'b0);
    step("shl", 1'b1, 3'd1, 16'h0, 1'b1, 1'b0);
    chk("shl q8", {8'h00, q8}, 16'h004B);
    chk("shl souts", {14'd0, sout_l8, sout_r8}, 16'h0001);
    step("shr", 1'b1, 3'd2, 16'h0, 1'b0, 1'b0);
    chk("shr q8", {8'h00, q8}, 16'h0025);

    // LOAD 81, 8 ROL
    step("load_81", 1'b1, 3'd3, 16'h0081, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step("rol8", 1'b1, 3'd4, 16'h0, 1'b0, 1'b0);
    chk("rol8 q8", {8'h00, q8}, 16'h0081);
    chk("rol8 done8", {15'd0, done8}, 16'h0001);
    step("hold_after_rol", 1'b1, 3'd0, 16'h0, 1'b0, 1'b0);
    chk("done8 cleared", {15'd0, done8}, 16'h0000);

    // LOAD 0F, 3 SHR, en=0 x4, 5 SHR
    step("load_0f", 1'b1, 3'd3, 16'h000F, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("shr3", 1'b1, 3'd2, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step("en_low", 1'b0, 3'd1, 16'h0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step("shr5", 1'b1, 3'd2, 16'h0, 1'b0, 1'b0);
    chk("shr8 q8", {8'h00, q8}, 16'h0000);
    chk("shr8 done8", {15'd0, done8}, 16'h0001);

    // Reserved codes hold
    step("load_3c", 1'b1, 3'd3, 16'h003C, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("reserved", 1'b1, 3'(6 + (i % 2)), 16'hFFFF, 1'b1, 1'b1);
    chk("reserved q8", {8'h00, q8}, 16'h003C);

    // Reset aborts a count in progress
    for (int i = 0; i < 4; i++) step("ror_a", 1'b1, 3'd5, 16'h0, 1'b0, 1'b0);
    pulse_reset("abort_reset");
    for (int i = 0; i < 4; i++) step("ror_b", 1'b1, 3'd5, 16'h0, 1'b0, 1'b0);
    chk("abort no done8", {15'd0, done8}, 16'h0000);

    // 16-bit rotate sequence
    step("load_8001", 1'b1, 3'd3, 16'h8001, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step("ror16", 1'b1, 3'd5, 16'h0, 1'b0, 1'b0);
    chk("ror16 q16", q16, 16'h8001);
    chk("ror16 done16", {15'd0, done16}, 16'h0001);

    // Randomised traffic, with occasional mid-cycle resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) pulse_reset("rand_reset");
      else step("rand", $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                16'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Safety net: never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
